uart_tx_fifo_ctrl: RTL and testbench
====================================

UART_TX_FIFO_CTRL -- requirements
Module: uart_tx_fifo_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 SHALL have parameter GAP_CLKS, default 16, idle tx_clk cycles inserted after each tx_done; 0 disables the gap.
REQ-003 SHALL have port tx_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port tx_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  push request from the byte producer.
REQ-006 SHALL have port wr_data  input  8  byte to push.
REQ-007 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-008 SHALL have port empty  output  1  FIFO holds 0 entries.
REQ-009 SHALL have port level  output  $clog2(DEPTH)+1  current entry count.
REQ-010 SHALL have port tx_din  output  8  byte presented to the UART transmitter.
REQ-011 SHALL have port tx_start  output  1  single-cycle launch pulse to the transmitter.
REQ-012 SHALL have port tx_done  input  1  single-cycle completion pulse from the transmitter, tx_clk domain.
REQ-013 SHALL have port tx_busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL push wr_data when wr_en && !full; wr_en while full drops the byte, with no state change.
REQ-015 SHALL evaluate full before any same-cycle pop; a push while full is dropped even if a pop occurs that cycle.
REQ-016 SHALL make a pushed byte poppable no earlier than the cycle after the push.
REQ-017 SHALL use read/write pointers of $clog2(DEPTH)+1 bits that wrap modulo 2*DEPTH; full/empty are derived from the MSB and the index bits.
REQ-018 SHALL implement FSM states IDLE, START, WAIT_DONE, GAP.
REQ-019 IDLE: if !empty, pop the head into tx_din and go to START; otherwise stay.
REQ-020 START: assert tx_start for exactly one cycle, then go to WAIT_DONE.
REQ-021 WAIT_DONE: on tx_done go to GAP if GAP_CLKS>0, else to IDLE; wait indefinitely otherwise.
REQ-022 GAP: count GAP_CLKS cycles, then go to IDLE; the counter reloads on every entry.
REQ-023 SHALL hold tx_din stable from START through the end of WAIT_DONE.
REQ-024 SHALL ignore tx_done in IDLE, START and GAP.
REQ-025 Latency: a byte pushed at cycle N into an empty, idle block SHALL drive tx_start high at cycle N+2.
REQ-026 Back-to-back throughput with GAP_CLKS=0: tx_start SHALL rise 2 cycles after tx_done.

Reset
REQ-027 While tx_rst is high, SHALL force state IDLE, pointers 0, level 0, empty 1, full 0, tx_din 8'h00, tx_start 0, tx_busy 0 and gap counter 0.
REQ-028 Reset mid-transfer SHALL discard all FIFO contents and the in-flight byte; no tx_start follows until a new push.

Configuration
REQ-029 With UART_TX_FIFO_OVF_EN defined, SHALL add port overflow (output, 1), a sticky flag set by any dropped push and cleared only by tx_rst.
REQ-030 Without UART_TX_FIFO_OVF_EN, SHALL omit the overflow port and its logic; all other behaviour is identical.

Structure
REQ-031 The FSM state enum (tx_ctrl_state_e) and default DEPTH/GAP_CLKS constants SHALL live in package uart_pkg.
REQ-032 SHALL instantiate storage and pointer logic as sub-module uart_sync_fifo (push/pop/full/empty/level); the FSM stays in uart_tx_fifo_ctrl.

Verification
REQ-033 Reset, then push 8'hA5 at cycle 10 -> tx_start=1 at cycle 12 only, tx_din=8'hA5, tx_busy=1.
REQ-034 DEPTH=4: push 8'h01..8'h05 back-to-back while the transmitter stalls (no tx_done) -> first byte is popped, FIFO then holds 8'h02..8'h05 with full=1; a further push is dropped; with the macro defined, overflow=1 and stays 1.
REQ-035 GAP_CLKS=3: two queued bytes, pulse tx_done -> second tx_start exactly 3+2 cycles after tx_done.
REQ-036 Push and tx_done in the same cycle while full -> push dropped, level decrements by one on the following pop, no corruption.
REQ-037 Assert tx_rst in WAIT_DONE with 3 bytes queued -> empty=1, level=0, tx_start never rises after release until a new push.
REQ-038 Push 2*DEPTH+3 bytes with continuous drain -> all bytes are transmitted in order across pointer wrap.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit FIFO controller.
//   DefaultDepth    - default FIFO entry count
//   DefaultGapClks  - default idle cycles after each completed byte
//   tx_ctrl_state_e - transmit control FSM states
package uart_pkg;

    localparam int unsigned DefaultDepth   = 16;
    localparam int unsigned DefaultGapClks = 16;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StStart    = 2'd1,
        StWaitDone = 2'd2,
        StGap      = 2'd3
    } tx_ctrl_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extended read/write pointers.
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous active-high reset, clears the pointers
//   push_i   - write request, ignored while full
//   wdata_i  - write data
//   pop_i    - read request, ignored while empty
//   rdata_o  - head entry; valid whenever empty_o is low
//   full_o   - DEPTH entries held
//   empty_o  - no entries held
//   level_o  - current entry count
module uart_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned Aw = $clog2(DEPTH);

    // Pointers carry one extra bit so full and empty differ only in the MSB.
    logic [Aw:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    assign full_o  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[Aw-1:0]];

    // Full is judged on the registered pointers, so a same-cycle pop never frees a slot.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q[Aw-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Byte FIFO feeding a UART transmitter with a start/done handshake and an
// optional idle gap after each byte.
//   tx_clk   - clock, rising edge
//   tx_rst   - asynchronous active-high reset
//   wr_en    - push request; dropped while full
//   wr_data  - byte to push
//   full     - FIFO holds DEPTH entries
//   empty    - FIFO holds no entries
//   level    - current entry count
//   tx_din   - byte presented to the transmitter, held until tx_done
//   tx_start - one-cycle launch pulse
//   tx_done  - one-cycle completion pulse, honoured only while waiting for it
//   tx_busy  - high whenever the controller is not idle
//   overflow - sticky dropped-push flag, present only with UART_TX_FIFO_OVF_EN defined
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH    = DefaultDepth,
    parameter int unsigned GAP_CLKS = DefaultGapClks
) (
    input  logic                     tx_clk,
    input  logic                     tx_rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               tx_din,
    output logic                     tx_start,
    input  logic                     tx_done,
`ifdef UART_TX_FIFO_OVF_EN
    output logic                     overflow,
`endif
    output logic                     tx_busy
);

    localparam int unsigned GapW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    // Counter runs GAP_CLKS-1 down to 0, giving GAP_CLKS cycles in StGap.
    localparam logic [GapW-1:0] GapLoad = (GAP_CLKS > 0) ? GapW'(GAP_CLKS - 1) : '0;

    tx_ctrl_state_e  state_q, state_d;
    logic [GapW-1:0] gap_cnt_q;
    logic [7:0]      fifo_rdata;
    logic            pop;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (tx_clk),
        .rst_i   (tx_rst),
        .push_i  (wr_en),
        .wdata_i (wr_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    // State register
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (!empty) state_d = StStart;
            StStart:    state_d = StWaitDone;
            StWaitDone: if (tx_done) state_d = (GAP_CLKS > 0) ? StGap : StIdle;
            StGap:      if (gap_cnt_q == '0) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        pop      = (state_q == StIdle) && !empty;
        tx_start = (state_q == StStart);
        tx_busy  = (state_q != StIdle);
    end

    // Gap counter reloads on every entry into StGap.
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            gap_cnt_q <= '0;
        end else if (state_q == StWaitDone && tx_done) begin
            gap_cnt_q <= GapLoad;
        end else if (state_q == StGap && gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - GapW'(1);
        end
    end

    // Byte latched at pop and held through StStart and StWaitDone.
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst)   tx_din <= 8'h00;
        else if (pop) tx_din <= fifo_rdata;
    end

`ifdef UART_TX_FIFO_OVF_EN
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst)              overflow <= 1'b0;
        else if (wr_en && full)  overflow <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed self-checking bench for uart_tx_fifo_ctrl.
// dut: DEPTH=4, GAP_CLKS=3. dut0: DEPTH=4, GAP_CLKS=0 (back-to-back throughput).
module tb_uart_tx_fifo_ctrl;

    logic       tx_clk = 1'b0;
    logic       tx_rst;
    logic       wr_en, tx_done;
    logic [7:0] wr_data;
    logic       full, empty, tx_start, tx_busy;
    logic [2:0] level;
    logic [7:0] tx_din;

    logic       wr_en0, tx_done0;
    logic [7:0] wr_data0;
    logic       full0, empty0, tx_start0, tx_busy0;
    logic [2:0] level0;
    logic [7:0] tx_din0;
`ifdef UART_TX_FIFO_OVF_EN
    logic       overflow, overflow0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 tx_clk = ~tx_clk;

    uart_tx_fifo_ctrl #(
        .DEPTH    (4),
        .GAP_CLKS (3)
    ) dut (
        .tx_clk   (tx_clk),
        .tx_rst   (tx_rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .tx_din   (tx_din),
        .tx_start (tx_start),
        .tx_done  (tx_done),
`ifdef UART_TX_FIFO_OVF_EN
        .overflow (overflow),
`endif
        .tx_busy  (tx_busy)
    );

    uart_tx_fifo_ctrl #(
        .DEPTH    (4),
        .GAP_CLKS (0)
    ) dut0 (
        .tx_clk   (tx_clk),
        .tx_rst   (tx_rst),
        .wr_en    (wr_en0),
        .wr_data  (wr_data0),
        .full     (full0),
        .empty    (empty0),
        .level    (level0),
        .tx_din   (tx_din0),
        .tx_start (tx_start0),
        .tx_done  (tx_done0),
`ifdef UART_TX_FIFO_OVF_EN
        .overflow (overflow0),
`endif
        .tx_busy  (tx_busy0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    // Wait (bounded) for tx_start, check byte/level/latency, then answer with tx_done.
    task automatic xfer(input string tag, input logic [7:0] exp_byte, input int exp_wait,
                        input logic [2:0] exp_level);
        int n;
        n = 0;
        while (!tx_start && n < 40) begin
            tick();
            n++;
        end
        check_eq({tag, "_start"}, 32'(tx_start), 32'd1);
        check_eq({tag, "_din"}, 32'(tx_din), 32'(exp_byte));
        check_eq({tag, "_level"}, 32'(level), 32'(exp_level));
        check_eq({tag, "_wait"}, 32'(n), 32'(exp_wait));
        tick();
        check_eq({tag, "_one_cycle"}, 32'(tx_start), 32'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int pushed;
        int guard;
        int n;

        tx_rst   = 1'b1;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        tx_done  = 1'b0;
        wr_en0   = 1'b0;
        wr_data0 = 8'h00;
        tx_done0 = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_din", 32'(tx_din), 32'h00);
        check_eq("rst_start", 32'(tx_start), 32'd0);
        check_eq("rst_busy", 32'(tx_busy), 32'd0);
        tx_rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Single byte: push at N, tx_start at N+2 only
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        check_eq("lat_n1_start", 32'(tx_start), 32'd0);
        check_eq("lat_n1_level", 32'(level), 32'd1);
        check_eq("lat_n1_busy", 32'(tx_busy), 32'd0);
        xfer("a5", 8'hA5, 1, 3'd0);
        check_eq("a5_gap_busy", 32'(tx_busy), 32'd1);
        tick(); tick();
        check_eq("a5_gap_end_busy", 32'(tx_busy), 32'd1);
        tick();
        check_eq("a5_idle_busy", 32'(tx_busy), 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
        check_eq("ovf_clear", 32'(overflow), 32'd0);
`endif

        // Fill while transmitter stalls: 01 in flight, 02..05 queued
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        check_eq("fill_full", 32'(full), 32'd1);
        check_eq("fill_level", 32'(level), 32'd4);
        check_eq("fill_din", 32'(tx_din), 32'h01);
        check_eq("fill_busy", 32'(tx_busy), 32'd1);
        wr_en = 1'b1; wr_data = 8'h66;
        tick();
        wr_en = 1'b0;
        check_eq("drop_level", 32'(level), 32'd4);
        check_eq("drop_full", 32'(full), 32'd1);
        check_eq("drop_din", 32'(tx_din), 32'h01);
`ifdef UART_TX_FIFO_OVF_EN
        check_eq("ovf_set", 32'(overflow), 32'd1);
`endif
        // Push while full in the same cycle as tx_done: dropped
        wr_en = 1'b1; wr_data = 8'h77; tx_done = 1'b1;
        tick();
        wr_en = 1'b0; tx_done = 1'b0;
        check_eq("pd_level", 32'(level), 32'd4);
        check_eq("pd_full", 32'(full), 32'd1);
        xfer("q02", 8'h02, 4, 3'd3);
        xfer("q03", 8'h03, 4, 3'd2);
        xfer("q04", 8'h04, 4, 3'd1);
        xfer("q05", 8'h05, 4, 3'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (tx_start) seen++;
            tick();
        end
        check_eq("drain_no_extra", 32'(seen), 32'd0);
        check_eq("drain_empty", 32'(empty), 32'd1);
`ifdef UART_TX_FIFO_OVF_EN
        check_eq("ovf_sticky", 32'(overflow), 32'd1);
`endif

        // Reset in WAIT_DONE with 3 bytes queued
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'h11 * 8'(i + 1);
            tick();
        end
        wr_en = 1'b0;
        check_eq("mid_level", 32'(level), 32'd3);
        check_eq("mid_busy", 32'(tx_busy), 32'd1);
        tx_rst = 1'b1;
        #1;
        check_eq("arst_empty", 32'(empty), 32'd1);
        check_eq("arst_level", 32'(level), 32'd0);
        check_eq("arst_busy", 32'(tx_busy), 32'd0);
        check_eq("arst_din", 32'(tx_din), 32'h00);
`ifdef UART_TX_FIFO_OVF_EN
        check_eq("arst_ovf", 32'(overflow), 32'd0);
`endif
        tick(); tick();
        tx_rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (tx_start || !empty) seen++;
            tick();
        end
        check_eq("post_rst_quiet", 32'(seen), 32'd0);
        wr_en = 1'b1; wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        xfer("p5a", 8'h5A, 1, 3'd0);
        for (int i = 0; i < 5; i++) tick();

        // 2*DEPTH+3 bytes with continuous drain across pointer wrap
        pushed = 0;
        guard  = 0;
        fork
            begin
                while (pushed < 11 && guard < 400) begin
                    wr_data = 8'h30 + 8'(pushed);
                    wr_en   = !full;
                    tick();
                    if (wr_en) pushed++;
                    guard++;
                end
                wr_en = 1'b0;
            end
            begin
                for (int k = 0; k < 11; k++) begin
                    n = 0;
                    while (!tx_start && n < 60) begin
                        tick();
                        n++;
                    end
                    check_eq("wrap_start", 32'(tx_start), 32'd1);
                    check_eq("wrap_din", 32'(tx_din), 32'h30 + 32'(k));
                    tick();
                    tx_done = 1'b1;
                    tick();
                    tx_done = 1'b0;
                end
            end
        join
        check_eq("wrap_pushed", 32'(pushed), 32'd11);
        check_eq("wrap_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 5; i++) tick();

        // GAP_CLKS=0: tx_start two cycles after tx_done
        wr_en0 = 1'b1; wr_data0 = 8'hC1;
        tick();
        wr_data0 = 8'hC2;
        tick();
        wr_en0 = 1'b0;
        check_eq("g0_start1", 32'(tx_start0), 32'd1);
        check_eq("g0_din1", 32'(tx_din0), 32'hC1);
        tick();
        tx_done0 = 1'b1;
        tick();
        tx_done0 = 1'b0;
        check_eq("g0_done_p1", 32'(tx_start0), 32'd0);
        tick();
        check_eq("g0_done_p2", 32'(tx_start0), 32'd1);
        check_eq("g0_din2", 32'(tx_din0), 32'hC2);
        tick();
        tx_done0 = 1'b1;
        tick();
        tx_done0 = 1'b0;
        tick();
        check_eq("g0_idle", 32'(tx_busy0), 32'd0);
        check_eq("g0_empty", 32'(empty0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
